// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS fetch stage: state encoding, vectors, widths
// and the redirect bundle handed from the top to the next-PC selector.
package mips_defs;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0080;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              jump;
    logic [25:0]       jump_index;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
  } redirect_t;
endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jr > jump > branch > sequential) with misalignment
// detect on redirect targets; the sequential path is trusted and never flagged.
module next_pc_sel
  import mips_defs::*;
(
  input  logic [ADDR_W-1:0] pc_plus4,
  input  redirect_t         rd,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);
  logic [ADDR_W-1:0] jump_tgt;

  assign jump_tgt = {pc_plus4[31:28], rd.jump_index, 2'b00};

  always_comb begin
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    if (rd.jr) begin
      next_pc    = rd.jr_target;
      misaligned = |rd.jr_target[1:0];
    end else if (rd.jump) begin
      next_pc    = jump_tgt;
    end else if (rd.branch_taken) begin
      next_pc    = rd.branch_target;
      misaligned = |rd.branch_target[1:0];
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and imem wait-timeout for the single-cycle MIPS core.
// PC + 4 comes back from the external adder_32b; no address arithmetic here.
module pc_fetch_unit
  import mips_defs::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int                MEM_TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  output logic              fetch_valid,
  output logic              addr_err,
  output logic              halted
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc_d, next_pc;
  logic [CNT_W-1:0]  wait_cnt, cnt_d;
  logic              err_d, misaligned, accept;
  redirect_t         rd;

  assign rd = '{jr: jr, jr_target: jr_target, jump: jump, jump_index: jump_index,
                branch_taken: branch_taken, branch_target: branch_target};

  next_pc_sel u_sel (
    .pc_plus4   (pc_plus4),
    .rd         (rd),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      wait_cnt <= '0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      wait_cnt <= cnt_d;
      addr_err <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    cnt_d       = wait_cnt;
    err_d       = 1'b0;
    imem_req    = 1'b0;
    accept      = 1'b0;
    fetch_valid = 1'b0;
    case (state)
      BOOT: state_d = FETCH;
      FETCH: begin
        imem_req    = 1'b1;
        accept      = imem_ready & ~stall;
        fetch_valid = accept;
        if (accept) begin
          cnt_d = '0;
          if (misaligned) begin
            pc_d  = EXC_VECTOR;
            err_d = 1'b1;
          end else begin
            pc_d  = next_pc;
          end
          // halt is taken only after the accepted fetch has redirected the PC
          if (halt_req) state_d = HALT;
        end else if (stall) begin
          cnt_d = '0;
        end else if (wait_cnt == CNT_LAST) begin
          pc_d  = EXC_VECTOR;
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      HALT: ;
      default: state_d = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with the adder_32b loop modelled as pc + 4.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, branch_taken, jump, jr, stall, halt_req, imem_ready;
  logic [31:0] pc_plus4, branch_target, jr_target, pc, imem_addr;
  logic [25:0] jump_index;
  logic        imem_req, fetch_valid, addr_err, halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fl;   // {imem_req, fetch_valid, addr_err, halted}
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  assign pc_plus4 = pc + 32'd4;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .stall(stall), .halt_req(halt_req), .imem_ready(imem_ready),
    .pc(pc), .imem_addr(imem_addr), .imem_req(imem_req),
    .fetch_valid(fetch_valid), .addr_err(addr_err), .halted(halted)
  );

  task automatic clr();
    branch_taken = 0; jump = 0; jr = 0; stall = 0; halt_req = 0;
    branch_target = '0; jr_target = '0; jump_index = '0;
  endtask

  // Inputs for the current cycle are already driven; compare, then move to next negedge.
  task automatic chk(input string tag, input logic [31:0] epc, input logic [3:0] efl);
    exp_t e;
    logic [3:0] ofl;
    exp_q.push_back('{pc: epc, fl: efl});
    #1;
    e   = exp_q.pop_front();
    ofl = {imem_req, fetch_valid, addr_err, halted};
    n_cmp++;
    assert (pc === e.pc) else begin
      n_err++; $error("FAIL %s pc got %h want %h", tag, pc, e.pc);
    end
    n_cmp++;
    assert (imem_addr === e.pc) else begin
      n_err++; $error("FAIL %s imem_addr got %h want %h", tag, imem_addr, e.pc);
    end
    n_cmp++;
    assert (ofl === e.fl) else begin
      n_err++; $error("FAIL %s req/fv/err/halt got %b want %b", tag, ofl, e.fl);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; imem_ready = 0; clr();
    @(negedge clk);
    chk("reset", 32'h0, 4'b0000);
    rst_n = 1; imem_ready = 1;
    chk("boot", 32'h0, 4'b0000);
    chk("seq0", 32'h0, 4'b1100);
    chk("seq4", 32'h4, 4'b1100);
    jr = 1; jump = 1; branch_taken = 1;
    jr_target = 32'h100; jump_index = 26'h40; branch_target = 32'h20;
    chk("prio_all", 32'h8, 4'b1100);
    clr(); jump = 1; jump_index = 26'h40;
    chk("jr_taken", 32'h100, 4'b1100);
    clr(); branch_taken = 1; branch_target = 32'h22;
    chk("jump_taken", 32'h100, 4'b1100);
    clr(); jr = 1; jr_target = 32'h10;
    chk("misalign_trap", 32'h80, 4'b1110);
    clr(); imem_ready = 0;
    for (int i = 0; i < 16; i++) chk($sformatf("wait%0d", i), 32'h10, 4'b1000);
    chk("timeout_trap", 32'h80, 4'b1010);
    imem_ready = 1; jr = 1; jr_target = 32'h10;
    chk("exc_accept", 32'h80, 4'b1100);
    clr(); imem_ready = 0;
    for (int i = 0; i < 10; i++) chk($sformatf("pre_stall%0d", i), 32'h10, 4'b1000);
    stall = 1;
    chk("mid_stall", 32'h10, 4'b1000);
    stall = 0;
    for (int i = 0; i < 15; i++) chk($sformatf("post_stall%0d", i), 32'h10, 4'b1000);
    imem_ready = 1; jr = 1; jr_target = 32'h20;
    chk("no_trap", 32'h10, 4'b1100);
    clr(); stall = 1;
    for (int i = 0; i < 3; i++) chk($sformatf("stall%0d", i), 32'h20, 4'b1000);
    stall = 0;
    chk("unstall", 32'h20, 4'b1100);
    stall = 1; halt_req = 1; branch_taken = 1; branch_target = 32'h40;
    chk("halt_held_off", 32'h24, 4'b1000);
    stall = 0;
    chk("halt_accept", 32'h24, 4'b1100);
    clr(); jr = 1; jr_target = 32'h200;
    for (int i = 0; i < 10; i++) chk($sformatf("halted%0d", i), 32'h40, 4'b0001);
    clr(); rst_n = 0;
    chk("rst_in_halt", 32'h40, 4'b0001);
    rst_n = 1;
    chk("reboot", 32'h0, 4'b0000);
    halt_req = 1; branch_taken = 1; branch_target = 32'h22;
    chk("mis_halt", 32'h0, 4'b1100);
    clr();
    chk("mis_halt_after", 32'h80, 4'b0011);
    chk("mis_halt_pulse", 32'h80, 4'b0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
